// File: rtl/rv_mem_arbiter.sv
// Shares one single-port synchronous memory between CPU fetch, CPU data and host ports.
// One access per cycle; a tag pipe routes read returns back to whoever issued them.
module rv_mem_arbiter #(
    parameter int g_addr_width   = 14,
    parameter int g_read_latency = 1,
    parameter int g_max_starve   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [31:0]             im_addr_i,
    output logic [31:0]             im_data_o,
    output logic                    im_valid_o,
    output logic [31:0]             im_data_addr_o,
    input  logic [31:0]             dm_addr_i,
    input  logic [31:0]             dm_data_s_i,
    input  logic [3:0]              dm_data_select_i,
    input  logic                    dm_load_i,
    input  logic                    dm_store_i,
    output logic                    dm_ready_o,
    output logic [31:0]             dm_data_l_o,
    output logic                    dm_load_done_o,
    output logic                    dm_store_done_o,
    input  logic                    host_req_i,
    input  logic                    host_we_i,
    input  logic [31:0]             host_addr_i,
    input  logic [31:0]             host_data_i,
    output logic [31:0]             host_data_o,
    output logic                    host_ack_o,
    output logic [g_addr_width-1:0] mem_addr_o,
    output logic [31:0]             mem_data_o,
    output logic [3:0]              mem_we_o,
    output logic                    mem_en_o,
    input  logic [31:0]             mem_data_i
);
    localparam int AW = g_addr_width;
    localparam int L  = g_read_latency;
    localparam int SW = $clog2(g_max_starve + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(g_max_starve);
    localparam logic [1:0] SRC_FETCH = 2'd0;
    localparam logic [1:0] SRC_DATA  = 2'd1;
    localparam logic [1:0] SRC_HOST  = 2'd2;

    // run_q keeps the memory quiet for the first cycle after reset release
    logic          run_q, run_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          dm_busy_q, dm_busy_d, dm_issued_q, dm_issued_d, dm_we_q, dm_we_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]   dm_wdata_q, dm_wdata_d;
    logic [3:0]    dm_sel_q, dm_sel_d;
    logic          dm_sdone_q, dm_sdone_d;
    logic          host_busy_q, host_busy_d, host_issued_q, host_issued_d, host_we_q, host_we_d;
    logic [AW-1:0] host_addr_q, host_addr_d;
    logic [31:0]   host_wdata_q, host_wdata_d;
    logic          host_wack_q, host_wack_d;
    logic [L-1:0]        tag_v_q, tag_v_d;
    logic [L-1:0][1:0]   tag_src_q, tag_src_d;
    logic [L-1:0][31:0]  tag_addr_q, tag_addr_d;

    logic       force_fetch, gnt_host, gnt_data, gnt_fetch;
    logic       iss_read;
    logic [1:0] iss_src;
    logic       ret_v, host_rd_ack, dm_done, dm_accept;
    logic [1:0] ret_src;
    logic       unused_bits;

    assign unused_bits = ^{dm_addr_i, host_addr_i};

    // Grant is purely a function of registered state, so it never depends on same-cycle requests
    assign force_fetch = (starve_q == STARVE_MAX);
    assign gnt_host    = run_q && !force_fetch && host_busy_q && !host_issued_q;
    assign gnt_data    = run_q && !force_fetch && !gnt_host && dm_busy_q && !dm_issued_q;
    assign gnt_fetch   = run_q && !gnt_host && !gnt_data;
    assign mem_en_o    = run_q;

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_we_o   = 4'h0;
        iss_read   = 1'b0;
        iss_src    = SRC_FETCH;
        if (gnt_host) begin
            mem_addr_o = host_addr_q;
            mem_data_o = host_wdata_q;
            mem_we_o   = host_we_q ? 4'hF : 4'h0;
            iss_read   = !host_we_q;
            iss_src    = SRC_HOST;
        end else if (gnt_data) begin
            mem_addr_o = dm_addr_q;
            mem_data_o = dm_wdata_q;
            mem_we_o   = dm_we_q ? dm_sel_q : 4'h0;
            iss_read   = !dm_we_q;
            iss_src    = SRC_DATA;
        end else if (gnt_fetch) begin
            mem_addr_o = im_addr_i[AW+1:2];
            iss_read   = 1'b1;
        end
    end

    assign tag_v_d[0]    = iss_read;
    assign tag_src_d[0]  = iss_src;
    assign tag_addr_d[0] = im_addr_i;
    genvar gi;
    for (gi = 1; gi < L; gi++) begin : g_tag_shift
        assign tag_v_d[gi]    = tag_v_q[gi-1];
        assign tag_src_d[gi]  = tag_src_q[gi-1];
        assign tag_addr_d[gi] = tag_addr_q[gi-1];
    end

    assign ret_v   = tag_v_q[L-1];
    assign ret_src = tag_src_q[L-1];

    always_comb begin
        im_valid_o      = ret_v && (ret_src == SRC_FETCH);
        im_data_o       = im_valid_o ? mem_data_i : '0;
        im_data_addr_o  = im_valid_o ? tag_addr_q[L-1] : '0;
        dm_load_done_o  = ret_v && (ret_src == SRC_DATA);
        dm_data_l_o     = dm_load_done_o ? mem_data_i : '0;
        dm_store_done_o = dm_sdone_q;
        host_rd_ack     = ret_v && (ret_src == SRC_HOST);
        host_ack_o      = host_rd_ack || host_wack_q;
        host_data_o     = host_rd_ack ? mem_data_i : '0;
    end

    // Ready reopens in the done cycle so a new request can be taken back-to-back
    assign dm_done    = dm_load_done_o || dm_sdone_q;
    assign dm_ready_o = !dm_busy_q || dm_done;
    assign dm_accept  = dm_ready_o && (dm_load_i || dm_store_i);

    always_comb begin
        run_d         = 1'b1;
        starve_d      = starve_q;
        dm_busy_d     = dm_busy_q;
        dm_issued_d   = dm_issued_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        dm_sel_d      = dm_sel_q;
        dm_sdone_d    = gnt_data && dm_we_q;
        host_busy_d   = host_busy_q;
        host_issued_d = host_issued_q;
        host_we_d     = host_we_q;
        host_addr_d   = host_addr_q;
        host_wdata_d  = host_wdata_q;
        host_wack_d   = gnt_host && host_we_q;

        if (gnt_fetch)
            starve_d = '0;
        else if (run_q && !force_fetch)
            starve_d = starve_q + 1'b1;

        if (dm_done)  dm_busy_d   = 1'b0;
        if (gnt_data) dm_issued_d = 1'b1;
        if (dm_accept) begin
            dm_busy_d   = 1'b1;
            dm_issued_d = 1'b0;
            dm_we_d     = dm_store_i;
            dm_addr_d   = dm_addr_i[AW+1:2];
            dm_wdata_d  = dm_data_s_i;
            dm_sel_d    = dm_data_select_i;
        end

        if (host_ack_o) host_busy_d   = 1'b0;
        if (gnt_host)   host_issued_d = 1'b1;
        if (!host_busy_q && host_req_i) begin
            host_busy_d   = 1'b1;
            host_issued_d = 1'b0;
            host_we_d     = host_we_i;
            host_addr_d   = host_addr_i[AW+1:2];
            host_wdata_d  = host_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q         <= 1'b0;
            starve_q      <= '0;
            dm_busy_q     <= 1'b0;
            dm_issued_q   <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            dm_sel_q      <= '0;
            dm_sdone_q    <= 1'b0;
            host_busy_q   <= 1'b0;
            host_issued_q <= 1'b0;
            host_we_q     <= 1'b0;
            host_addr_q   <= '0;
            host_wdata_q  <= '0;
            host_wack_q   <= 1'b0;
            tag_v_q       <= '0;
            tag_src_q     <= '0;
            tag_addr_q    <= '0;
        end else begin
            run_q         <= run_d;
            starve_q      <= starve_d;
            dm_busy_q     <= dm_busy_d;
            dm_issued_q   <= dm_issued_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            dm_sel_q      <= dm_sel_d;
            dm_sdone_q    <= dm_sdone_d;
            host_busy_q   <= host_busy_d;
            host_issued_q <= host_issued_d;
            host_we_q     <= host_we_d;
            host_addr_q   <= host_addr_d;
            host_wdata_q  <= host_wdata_d;
            host_wack_q   <= host_wack_d;
            tag_v_q       <= tag_v_d;
            tag_src_q     <= tag_src_d;
            tag_addr_q    <= tag_addr_d;
        end
    end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: a latency-1 instance for the main traffic and a
// latency-3 instance for the reset-during-read case.
`timescale 1ns/1ps
module tb_rv_mem_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- latency-1 instance ----------------
    logic        rst_n;
    logic [31:0] im_addr, im_data, im_data_addr;
    logic        im_valid;
    logic [31:0] dm_addr, dm_data_s, dm_data_l;
    logic [3:0]  dm_sel;
    logic        dm_load, dm_store, dm_ready, dm_load_done, dm_store_done;
    logic        host_req, host_we, host_ack;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic        mem_en;

    rv_mem_arbiter #(.g_addr_width(14), .g_read_latency(1), .g_max_starve(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid), .im_data_addr_o(im_data_addr),
        .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
        .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_ready_o(dm_ready),
        .dm_data_l_o(dm_data_l), .dm_load_done_o(dm_load_done), .dm_store_done_o(dm_store_done),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_data_i(host_wdata),
        .host_data_o(host_rdata), .host_ack_o(host_ack),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_we_o(mem_we), .mem_en_o(mem_en),
        .mem_data_i(mem_rdata)
    );

    // Memory model, word i preloads to 0xA5000000 | i
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // ---------------- latency-3 instance ----------------
    logic        b_rst_n;
    logic [31:0] b_im_addr, b_im_data, b_im_data_addr;
    logic        b_im_valid;
    logic [31:0] b_dm_addr, b_dm_data_l;
    logic        b_dm_load, b_dm_ready, b_dm_load_done, b_dm_store_done;
    logic        b_host_ack;
    logic [31:0] b_host_rdata;
    logic [13:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_rd0, b_rd1, b_rd2;
    logic [3:0]  b_mem_we;
    logic        b_mem_en;

    rv_mem_arbiter #(.g_addr_width(14), .g_read_latency(3), .g_max_starve(4)) dut3 (
        .clk_i(clk), .rst_n_i(b_rst_n),
        .im_addr_i(b_im_addr), .im_data_o(b_im_data), .im_valid_o(b_im_valid), .im_data_addr_o(b_im_data_addr),
        .dm_addr_i(b_dm_addr), .dm_data_s_i(32'h0), .dm_data_select_i(4'h0),
        .dm_load_i(b_dm_load), .dm_store_i(1'b0), .dm_ready_o(b_dm_ready),
        .dm_data_l_o(b_dm_data_l), .dm_load_done_o(b_dm_load_done), .dm_store_done_o(b_dm_store_done),
        .host_req_i(1'b0), .host_we_i(1'b0), .host_addr_i(32'h0), .host_data_i(32'h0),
        .host_data_o(b_host_rdata), .host_ack_o(b_host_ack),
        .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_wdata), .mem_we_o(b_mem_we), .mem_en_o(b_mem_en),
        .mem_data_i(b_rd2)
    );

    always @(posedge clk) begin
        b_rd0 <= 32'hB000_0000 | 32'(b_mem_addr);
        b_rd1 <= b_rd0;
        b_rd2 <= b_rd1;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] q_load[$];
    logic [32:0] q_host[$];   // {is_write, read data}
    bit          q_store[$];
    bit          gap_en = 1'b0;
    int          gap = 0, max_gap = 0, fetch_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (im_valid) begin
                $display("[TB] fetch  addr=%h data=%h", im_data_addr, im_data);
                check("fetch_addr", im_data_addr, 32'h0000_0100);
                check("fetch_data", im_data, 32'hA500_0040);
            end
            if (dm_load_done) begin
                $display("[TB] load   data=%h", dm_data_l);
                if (q_load.size() == 0) check("unexpected_load_done", 32'd1, 32'd0);
                else check("load_data", dm_data_l, q_load.pop_front());
            end
            if (dm_store_done) begin
                $display("[TB] store  done");
                if (q_store.size() == 0) check("unexpected_store_done", 32'd1, 32'd0);
                else void'(q_store.pop_front());
            end
            if (host_ack) begin
                $display("[TB] host   ack data=%h", host_rdata);
                if (q_host.size() == 0) check("unexpected_host_ack", 32'd1, 32'd0);
                else begin
                    logic [32:0] e;
                    e = q_host.pop_front();
                    if (!e[32]) check("host_rdata", host_rdata, e[31:0]);
                end
            end
            if (gap_en && mem_en) begin
                if (mem_we != 4'h0) begin
                    gap++;
                    if (gap > max_gap) max_gap = gap;
                end else begin
                    gap = 0;
                    fetch_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic host_write_burst(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            host_req   = 1'b1;
            host_we    = 1'b1;
            host_addr  = 32'h0000_0200;
            host_wdata = 32'hCAFE_0000 | 32'(k);
            q_host.push_back({1'b1, 32'h0});
            t = 0;
            do begin
                tick();
                t++;
            end while (!host_ack && t < 20);
            check("host_ack_in_time", 32'(t < 20), 32'd1);
        end
        host_req = 1'b0;
    endtask

    task automatic data_store_stream(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (dm_ready) begin
                dm_store  = 1'b1;
                dm_addr   = 32'h0000_0204;
                dm_data_s = 32'h5500_0000 | 32'(i);
                dm_sel    = 4'hF;
                q_store.push_back(1'b1);
            end else begin
                dm_store = 1'b0;
            end
        end
        tick();
        dm_store = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        im_addr = 32'h100; dm_addr = '0; dm_data_s = '0; dm_sel = '0; dm_load = 0; dm_store = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        b_im_addr = 32'h100; b_dm_addr = '0; b_dm_load = 0;
        repeat (3) tick();
        check("rst_dm_ready", 32'(dm_ready), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_im_valid", 32'(im_valid), 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_store_done", 32'(dm_store_done), 32'd0);
        rst_n = 1'b1; b_rst_n = 1'b1;

        // Idle fetch stream
        check("first_cycle_mem_en", 32'(mem_en), 32'd0);
        tick();
        check("fetch_issue_mem_en", 32'(mem_en), 32'd1);
        check("fetch_addr_out", 32'(mem_addr), 32'h40);
        check("no_valid_yet", 32'(im_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_mem_en", 32'(mem_en), 32'd1);
            check("idle_im_valid", 32'(im_valid), 32'd1);
        end

        // Byte-enabled store
        check("store_ready", 32'(dm_ready), 32'd1);
        dm_addr = 32'h40; dm_data_s = 32'hDEAD_BEEF; dm_sel = 4'b0011; dm_store = 1'b1;
        q_store.push_back(1'b1);
        tick();
        dm_store = 1'b0;
        check("store_we", 32'(mem_we), 32'h3);
        check("store_addr", 32'(mem_addr), 32'h10);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("store_busy", 32'(dm_ready), 32'd0);
        tick();
        check("store_done", 32'(dm_store_done), 32'd1);
        check("store_ready_again", 32'(dm_ready), 32'd1);

        // Host read and data load collide: host first
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
        dm_load = 1'b1; dm_addr = 32'h80;
        q_host.push_back({1'b0, 32'hA500_BEEF});
        q_load.push_back(32'hA500_0020);
        tick();
        dm_load = 1'b0;
        check("host_issue_addr", 32'(mem_addr), 32'h10);
        check("host_issue_we", 32'(mem_we), 32'h0);
        tick();
        check("data_issue_addr", 32'(mem_addr), 32'h20);
        check("host_ack_pulse", 32'(host_ack), 32'd1);
        check("load_not_yet", 32'(dm_load_done), 32'd0);
        host_req = 1'b0;
        tick();
        check("load_done_pulse", 32'(dm_load_done), 32'd1);
        check("host_ack_single", 32'(host_ack), 32'd0);

        // Load and store together: store wins
        tick();
        dm_load = 1'b1; dm_store = 1'b1; dm_addr = 32'h8; dm_data_s = 32'h1122_3344; dm_sel = 4'hF;
        q_store.push_back(1'b1);
        tick();
        dm_load = 1'b0; dm_store = 1'b0;
        check("ls_we", 32'(mem_we), 32'hF);
        check("ls_addr", 32'(mem_addr), 32'h2);
        tick();
        check("ls_store_done", 32'(dm_store_done), 32'd1);
        check("ls_no_load_done", 32'(dm_load_done), 32'd0);
        dm_load = 1'b1; dm_addr = 32'h8;
        q_load.push_back(32'h1122_3344);
        tick();
        dm_load = 1'b0;
        check("readback_addr", 32'(mem_addr), 32'h2);
        check("readback_we", 32'(mem_we), 32'h0);
        tick();
        check("readback_done", 32'(dm_load_done), 32'd1);

        // Host and data write pressure: fetch must still get through
        gap_en = 1'b1;
        fork
            host_write_burst(8);
            data_store_stream(30);
        join
        repeat (6) tick();
        gap_en = 1'b0;
        check("starve_gap_le_4", 32'(max_gap <= 4), 32'd1);
        check("fetch_got_slots", 32'(fetch_cnt > 0), 32'd1);

        // Latency-3 instance: reset lands one cycle before the load returns
        tick();
        check("b_ready", 32'(b_dm_ready), 32'd1);
        b_dm_load = 1'b1; b_dm_addr = 32'h80;
        tick();
        b_dm_load = 1'b0;
        check("b_issue_addr", 32'(b_mem_addr), 32'h20);
        check("b_busy", 32'(b_dm_ready), 32'd0);
        tick();
        check("b_no_done_early", 32'(b_dm_load_done), 32'd0);
        tick();
        b_rst_n = 1'b0;
        #1;
        check("b_rst_ready", 32'(b_dm_ready), 32'd1);
        check("b_rst_mem_en", 32'(b_mem_en), 32'd0);
        check("b_rst_im_valid", 32'(b_im_valid), 32'd0);
        tick();
        b_rst_n = 1'b1;
        check("b_rel_load_done", 32'(b_dm_load_done), 32'd0);
        check("b_rel_im_valid", 32'(b_im_valid), 32'd0);
        check("b_rel_mem_en", 32'(b_mem_en), 32'd0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (b_dm_load_done || b_host_ack || b_dm_store_done) pulses++;
            end
            check("b_no_stale_done", 32'(pulses), 32'd0);
            check("b_ready_after", 32'(b_dm_ready), 32'd1);
        end

        check("load_queue_empty", 32'(q_load.size()), 32'd0);
        check("store_queue_empty", 32'(q_store.size()), 32'd0);
        check("host_queue_empty", 32'(q_host.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
